// File: rtl/wb_timer_arbiter.sv
// wb_timer_arbiter: round-robin two-master Wishbone arbiter in front of the timer slave
module wb_timer_arbiter #(parameter int TIMEOUT_CYCLES = 16) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o
);
  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, last_q, last_d;
  logic req0, req1, win, busy, own, o_cyc, o_stb, tmo;
  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;
  assign win = (req0 & req1) ? ~last_q : req1;
  assign busy = state_q == BUSY;
  assign own = state_q != IDLE;
  assign o_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
  assign o_stb = owner_q ? m1_stb_i : m0_stb_i;
`ifdef WB_ARB_TIMEOUT_EN
  logic [7:0] wd_cnt_q, wd_cnt_d;
  assign tmo = busy && wd_cnt_q == 8'(TIMEOUT_CYCLES);
  always_comb wd_cnt_d = (!busy || s_ack_i) ? 8'd0 : s_stb_o ? wd_cnt_q + 8'd1 : wd_cnt_q;
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) wd_cnt_q <= 8'd0;
    else wd_cnt_q <= wd_cnt_d;
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d = last_q;
    if (state_q == IDLE) begin
      if (req0 | req1) begin
        state_d = BUSY;
        owner_d = win;
        last_d = win;
      end
    end else if (!o_cyc) state_d = IDLE;
    else if (tmo) state_d = ABORT;
  end
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
    end
  assign s_adr_o = own ? (owner_q ? m1_adr_i : m0_adr_i) : 32'd0;
  assign s_dat_o = own ? (owner_q ? m1_dat_i : m0_dat_i) : 32'd0;
  assign s_sel_o = own ? (owner_q ? m1_sel_i : m0_sel_i) : 4'd0;
  assign s_we_o = own & (owner_q ? m1_we_i : m0_we_i);
  assign s_cyc_o = busy & o_cyc;
  assign s_stb_o = busy & o_stb;
  assign grant_o = own ? {owner_q, ~owner_q} : 2'b00;
  assign m0_ack_o = busy & ~owner_q & s_ack_i;
  assign m1_ack_o = busy & owner_q & s_ack_i;
  assign m0_dat_o = (busy & ~owner_q) ? s_dat_i : 32'd0;
  assign m1_dat_o = (busy & owner_q) ? s_dat_i : 32'd0;
  assign m0_err_o = tmo & ~owner_q;
  assign m1_err_o = tmo & owner_q;
endmodule

// File: tb/tb_wb_timer_arbiter.sv
// tb_wb_timer_arbiter: randomized self-checking bench with a register-file slave model
module tb_wb_timer_arbiter;
  logic clk = 0, rst_n = 0, hang = 0;
  logic [31:0] m_adr[2], m_dat[2], m_rd[2];
  logic [3:0] m_sel[2];
  logic m_we[2], m_cyc[2], m_stb[2], m_ack[2], m_err[2];
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0] s_sel_o;
  logic s_we_o, s_cyc_o, s_stb_o, s_ack_i;
  logic [1:0] grant_o;
  logic [31:0] mem[256];
  int errors = 0, checks = 0, mon_bad = 0, ack_cnt[2], gap = 0, last_gap = -1;
  bit gq[$];
  logic [1:0] prev_g = 0;
  logic [31:0] rmodel[2][8];
  bit rvalid[2][8];

  always #5 clk = ~clk;

  wb_timer_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_n(rst_n),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_sel_i(m_sel[0]), .m0_we_i(m_we[0]),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_dat_o(m_rd[0]), .m0_ack_o(m_ack[0]), .m0_err_o(m_err[0]),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_sel_i(m_sel[1]), .m1_we_i(m_we[1]),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_dat_o(m_rd[1]), .m1_ack_o(m_ack[1]), .m1_err_o(m_err[1]),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .grant_o(grant_o));

  always @(posedge clk or negedge rst_n)
    if (!rst_n) s_ack_i <= 0;
    else begin
      s_ack_i <= s_cyc_o & s_stb_o & ~s_ack_i & ~hang;
      if (s_cyc_o & s_stb_o & ~s_ack_i & ~hang & s_we_o) mem[s_adr_o[9:2]] <= s_dat_o;
    end
  assign s_dat_i = mem[s_adr_o[9:2]];

  always @(negedge clk) if (rst_n) begin
    if (s_stb_o) begin
      if (!(grant_o == 2'b01 || grant_o == 2'b10)) mon_bad++;
      else if (s_adr_o !== m_adr[grant_o[1]] || s_we_o !== m_we[grant_o[1]] ||
               s_dat_o !== m_dat[grant_o[1]] || m_rd[grant_o[0]] !== 0) mon_bad++;
    end
    if (grant_o == 0 && (s_cyc_o || s_stb_o || s_adr_o != 0)) mon_bad++;
    for (int i = 0; i < 2; i++) begin
      if (m_ack[i] && !grant_o[i]) mon_bad++;
      ack_cnt[i] += int'(m_ack[i]);
`ifndef WB_ARB_TIMEOUT_EN
      if (m_err[i]) mon_bad++;
`endif
    end
    if (grant_o != 0) begin
      if (grant_o != prev_g) begin
        gq.push_back(grant_o[1]);
        last_gap = gap;
      end
      gap = 0;
    end else gap++;
    prev_g = grant_o;
  end

  task automatic clear_masters;
    for (int i = 0; i < 2; i++) begin
      m_adr[i] = 0; m_dat[i] = 0; m_sel[i] = 0; m_we[i] = 0; m_cyc[i] = 0; m_stb[i] = 0;
    end
  endtask

  task automatic apply_reset;
    rst_n = 0;
    clear_masters();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk) #1;
    gq.delete();
    prev_g = 0;
  endtask

  task automatic xfer(input int m, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      output logic [31:0] rd, output bit ok);
    m_cyc[m] = 1; m_stb[m] = 1; m_we[m] = we; m_adr[m] = adr; m_dat[m] = dat; m_sel[m] = 4'hf;
    ok = 0;
    rd = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (m_ack[m]) begin ok = 1; rd = m_rd[m]; end
    end
    @(posedge clk) #1;
    m_stb[m] = 0;
  endtask

  task automatic release_bus(input int m);
    m_cyc[m] = 0;
    @(posedge clk) #1;
  endtask

  task automatic test_reset;
    rst_n = 0;
    clear_masters();
    #3;
    checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b exp=00", grant_o); end
    checks++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) begin errors++; $display("FAIL reset_ctl got=%b exp=000", {s_cyc_o, s_stb_o, s_we_o}); end
    checks++; if ({s_adr_o, s_dat_o, s_sel_o} !== 68'd0) begin errors++; $display("FAIL reset_bus got=%h exp=0", {s_adr_o, s_dat_o, s_sel_o}); end
    checks++; if ({m_ack[0], m_ack[1], m_err[0], m_err[1], m_rd[0], m_rd[1]} !== 68'd0) begin errors++; $display("FAIL reset_master_outs nonzero"); end
    apply_reset();
  endtask

  task automatic test_single;
    logic [31:0] rd; bit ok; int a0;
    a0 = ack_cnt[0];
    m_cyc[0] = 1; m_stb[0] = 1; m_we[0] = 1; m_adr[0] = 32'h4; m_dat[0] = 32'h1234; m_sel[0] = 4'hf;
    @(negedge clk);
    checks++; if (s_stb_o !== 1'b0) begin errors++; $display("FAIL single_stb_early got=%b exp=0", s_stb_o); end
    @(negedge clk);
    checks++; if (s_stb_o !== 1'b1 || grant_o !== 2'b01) begin errors++; $display("FAIL single_stb_latency got stb=%b grant=%b exp 1/01", s_stb_o, grant_o); end
    xfer(0, 1, 32'h4, 32'h1234, rd, ok);
    checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL single_grant_hold got=%b exp=01", grant_o); end
    xfer(0, 0, 32'h4, 32'h0, rd, ok);
    checks++; if (!ok || rd !== 32'h1234) begin errors++; $display("FAIL single_read got=%h exp=00001234", rd); end
    release_bus(0);
    checks++; if (ack_cnt[0] - a0 !== 2) begin errors++; $display("FAIL single_ack_count got=%0d exp=2", ack_cnt[0] - a0); end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_simultaneous;
    logic [31:0] r0, r1; bit k0, k1;
    apply_reset();
    fork
      begin xfer(0, 1, 32'h20, 32'hA0, r0, k0); release_bus(0); end
      begin xfer(1, 1, 32'h24, 32'hB1, r1, k1); release_bus(1); end
    join
    checks++; if (gq.size() != 2 || gq[0] !== 1'b0 || gq[1] !== 1'b1) begin errors++; $display("FAIL simul_order got size=%0d exp 0 then 1", gq.size()); end
    checks++; if (last_gap != 1) begin errors++; $display("FAIL simul_dead_cycle got=%0d exp=1", last_gap); end
    checks++; if (!(k0 && k1)) begin errors++; $display("FAIL simul_done got=%b%b exp=11", k0, k1); end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_contention;
    bit ok_all = 1; int prev = -1, exp_g;
    gq.delete();
    fork
      for (int i = 0; i < 4; i++) begin logic [31:0] r; bit k; xfer(0, 1, 32'h40 + i * 4, $urandom, r, k); if (!k) ok_all = 0; release_bus(0); end
      for (int i = 0; i < 4; i++) begin logic [31:0] r; bit k; xfer(1, 1, 32'h60 + i * 4, $urandom, r, k); if (!k) ok_all = 0; release_bus(1); end
    join
    checks++; if (gq.size() != 8 || !ok_all) begin errors++; $display("FAIL contention_count got=%0d exp=8 done=%b", gq.size(), ok_all); end
    for (int i = 0; i < 8 && i < gq.size(); i++) begin
      exp_g = (prev < 0) ? 0 : 1 - prev;
      checks++; if (int'(gq[i]) != exp_g) begin errors++; $display("FAIL contention_grant[%0d] got=%0d exp=%0d", i, gq[i], exp_g); end
      prev = exp_g;
    end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_rmw;
    logic [31:0] rd, rm; bit k; time t_rel = 0, t_ack = 0;
    xfer(1, 1, 32'h8, 32'h55, rd, k); release_bus(1);
    fork
      begin xfer(1, 0, 32'h8, 0, rm, k); xfer(1, 1, 32'h8, rm + 32'h10, rd, k); t_rel = $time; release_bus(1); end
      begin @(posedge clk) #1; xfer(0, 1, 32'hC, 32'hAA, rd, k); t_ack = $time; release_bus(0); end
    join
    checks++; if (rm !== 32'h55) begin errors++; $display("FAIL rmw_read got=%h exp=00000055", rm); end
    checks++; if (t_ack <= t_rel) begin errors++; $display("FAIL rmw_lock m0 done at %0t, m1 released at %0t", t_ack, t_rel); end
    xfer(0, 0, 32'h8, 0, rd, k); release_bus(0);
    checks++; if (rd !== 32'h65) begin errors++; $display("FAIL rmw_value got=%h exp=00000065", rd); end
  endtask

  task automatic test_random;
    fork
      for (int m = 0; m < 2; m++) begin
        automatic int mm = m;
        fork
          for (int n = 0; n < 12; n++) begin
            logic [31:0] rd, d; bit k, we; int idx;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            idx = $urandom_range(0, 7);
            we = !rvalid[mm][idx] || ($urandom_range(0, 1) == 1);
            d = $urandom;
            xfer(mm, we, 32'h100 * (mm + 1) + idx * 4, d, rd, k);
            checks++;
            if (!k) begin errors++; $display("FAIL random_timeout m%0d n%0d", mm, n); end
            else if (we) begin rmodel[mm][idx] = d; rvalid[mm][idx] = 1; end
            else if (rd !== rmodel[mm][idx]) begin errors++; $display("FAIL random_read m%0d idx%0d got=%h exp=%h", mm, idx, rd, rmodel[mm][idx]); end
            if ($urandom_range(0, 1) == 1 || n == 11) release_bus(mm);
          end
        join_none
      end
      wait fork;
    join
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic [31:0] r0, r1; bit k0, k1;
    m_cyc[0] = 1; m_stb[0] = 1; m_we[0] = 1; m_adr[0] = 32'h10; m_dat[0] = 32'h77; m_sel[0] = 4'hf;
    repeat (2) @(negedge clk);
    #2 rst_n = 0;
    #1;
    checks++; if ({s_cyc_o, s_stb_o, grant_o} !== 4'b0000 || s_adr_o !== 0) begin errors++; $display("FAIL reset_mid got cyc=%b stb=%b grant=%b adr=%h exp 0", s_cyc_o, s_stb_o, grant_o, s_adr_o); end
    clear_masters();
    @(negedge clk) rst_n = 1;
    @(posedge clk) #1;
    gq.delete();
    fork
      begin xfer(0, 1, 32'h30, 32'h1, r0, k0); release_bus(0); end
      begin xfer(1, 1, 32'h34, 32'h2, r1, k1); release_bus(1); end
    join
    checks++; if (gq.size() < 1 || gq[0] !== 1'b0) begin errors++; $display("FAIL reset_mid_tie got first=%0d exp=0", gq.size() ? int'(gq[0]) : -1); end
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  task automatic test_timeout;
    int stb_at = -1, err_at = -1, err_n = 0;
    apply_reset();
    hang = 1;
    m_cyc[0] = 1; m_stb[0] = 1; m_we[0] = 1; m_adr[0] = 32'h50; m_sel[0] = 4'hf;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (s_stb_o && stb_at < 0) stb_at = n;
      if (m_err[0]) begin if (err_at < 0) err_at = n; err_n++; end
    end
    checks++; if (stb_at < 0 || err_at - stb_at != 4) begin errors++; $display("FAIL timeout_latency got=%0d exp=4", err_at - stb_at); end
    checks++; if (err_n != 1) begin errors++; $display("FAIL timeout_pulse got=%0d exp=1", err_n); end
    checks++; if (s_stb_o !== 1'b0 || grant_o !== 2'b01) begin errors++; $display("FAIL timeout_abort got stb=%b grant=%b exp 0/01", s_stb_o, grant_o); end
    @(posedge clk) #1 clear_masters();
    repeat (2) @(negedge clk);
    checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL timeout_idle got=%b exp=00", grant_o); end
    hang = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_contention();
    test_rmw();
    test_random();
    test_reset_mid();
`ifdef WB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    checks++; if (mon_bad != 0) begin errors++; $display("FAIL bus_monitor got=%0d exp=0 violations", mon_bad); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
